// File: rtl/pwm_axi_lite_slave.sv
// AXI4-Lite register slave for the PWM block: CTRL/PERIOD/DUTY/STATUS registers,
// one-entry AW and W holding buffers, and a shadowed free-running PWM counter.
module pwm_axi_lite_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_PWM_WIDTH        = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              pwm_out
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    typedef logic [C_PWM_WIDTH-1:0] pwm_t;

    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPeriod = 2'd1;
    localparam logic [1:0] RegDuty   = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    function automatic pwm_t merge_strb(pwm_t old_val, logic [DW-1:0] data, logic [SW-1:0] strb);
        pwm_t res;
        for (int i = 0; i < int'(C_PWM_WIDTH); i++) begin
            res[i] = strb[i / 8] ? data[i] : old_val[i];
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] zext(pwm_t v);
        logic [DW-1:0] r;
        r = '0;
        r[C_PWM_WIDTH-1:0] = v;
        return r;
    endfunction

    logic          aw_full_q, aw_full_d;
    logic [1:0]    aw_idx_q, aw_idx_d;
    logic          w_full_q, w_full_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [SW-1:0] w_strb_q, w_strb_d;
    logic          bvalid_q, bvalid_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    ctrl_q, ctrl_d;
    pwm_t          period_q, period_d;
    pwm_t          duty_q, duty_d;
    pwm_t          cnt_q, cnt_d;
    pwm_t          per_sh_q, per_sh_d;
    pwm_t          duty_sh_q, duty_sh_d;
    logic          en_prev_q, en_prev_d;
    logic          pwm_q, pwm_d;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [DW-1:0] rd_val;
    logic          en, pol, start, wrap;
    pwm_t          p_cur, d_cur;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel: independent AW/W buffers, commit once both hold a beat.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        ctrl_d    = ctrl_q;
        period_d  = period_q;
        duty_d    = duty_q;

        aw_hs  = S_AXI_AWVALID && awready_q;
        w_hs   = S_AXI_WVALID && wready_q;
        commit = aw_full_q && w_full_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            unique case (aw_idx_q)
                RegCtrl:   if (w_strb_q[0]) ctrl_d = w_data_q[1:0];
                RegPeriod: period_d = merge_strb(period_q, w_data_q, w_strb_q);
                RegDuty:   duty_d = merge_strb(duty_q, w_data_q, w_strb_q);
                RegStatus: ;
                default:   ;
            endcase
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;
    end

    // Read channel: reads sample the pre-edge register values.
    always_comb begin
        rd_val = '0;
        unique case (S_AXI_ARADDR[3:2])
            RegCtrl:   rd_val[1:0] = ctrl_q;
            RegPeriod: rd_val = zext(period_q);
            RegDuty:   rd_val = zext(duty_q);
            RegStatus: rd_val = zext(cnt_q);
            default:   rd_val = '0;
        endcase

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        ar_hs    = S_AXI_ARVALID && arready_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    // PWM: shadows reload on enable and at wrap so mid-period writes wait a period.
    always_comb begin
        en        = ctrl_q[0];
        pol       = ctrl_q[1];
        start     = en && !en_prev_q;
        p_cur     = start ? period_q : per_sh_q;
        d_cur     = start ? duty_q : duty_sh_q;
        wrap      = (p_cur != '0) && (cnt_q == p_cur - C_PWM_WIDTH'(1));
        en_prev_d = en;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        cnt_d     = '0;
        pwm_d     = pol;

        if (en) begin
            if (start || wrap) begin
                per_sh_d  = period_q;
                duty_sh_d = duty_q;
            end
            if (p_cur != '0) begin
                cnt_d = wrap ? '0 : cnt_q + C_PWM_WIDTH'(1);
                pwm_d = (cnt_q < d_cur) ^ pol;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            cnt_q     <= '0;
            per_sh_q  <= '0;
            duty_sh_q <= '0;
            en_prev_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            en_prev_q <= en_prev_d;
            pwm_q     <= pwm_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign pwm_out       = pwm_q;

endmodule

// File: doc/pwm_axi_lite_slave.md
Name: pwm_axi_lite_slave

Overview:
- AXI4-Lite responder for the PWM IP. It terminates the register bus driven by the system's AXI4-Lite master and answers its write and read bursts.
- It holds the control, period and duty registers and a free-running PWM counter, and drives one PWM output.
- It is the slave-side counterpart of the master BFM used in block-level tests. It sits between the AXI interconnect and the motor-driver pin.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers.
- C_PWM_WIDTH, 16, counter/period/duty width (1..32).

Ports:
- S_AXI_ACLK  in  1  single clock, rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- pwm_out  out  1  PWM output.

Behaviour:
- Reset: while ARESETN=0, all registers, the counter, the shadow registers and all AXI outputs are 0, and pwm_out=0.
- After reset release, AWREADY, WREADY and ARREADY rise on the first clock edge. All READY signals are registered.
- Register map, decoded on addr[3:2]:
  - 0x0 CTRL: bit0 EN, bit1 POL; other bits read as 0.
  - 0x4 PERIOD: bits [C_PWM_WIDTH-1:0].
  - 0x8 DUTY: bits [C_PWM_WIDTH-1:0].
  - 0xC STATUS: read-only current counter value; writes are accepted with OKAY and have no effect.
  - Bits above C_PWM_WIDTH read as 0.
- Write channel:
  - AW and W are accepted independently, in either order. Each has a one-entry holding buffer.
  - AWREADY = 1 when the AW buffer is empty and BVALID=0. WREADY follows the same rule for the W buffer.
  - A handshake captures the beat and drops the corresponding READY on the next edge.
  - On the first edge where both buffers are full, the register write commits per WSTRB byte lane, BVALID is set, and both buffers clear.
  - BVALID holds until BREADY=1. READYs re-assert the edge after B completes.
  - Only one write is outstanding at a time.
  - If AW and W arrive in the same cycle, latency from that handshake to BVALID is 1 cycle after the capture edge.
- Read channel:
  - ARREADY = 1 while RVALID=0.
  - On an AR handshake, RDATA is registered with the addressed value and RVALID is set on the same edge.
  - RDATA and RVALID hold until RREADY. ARREADY re-asserts the edge after R completes.
  - A read and a write to the same register on the same edge return the old value.
- PWM:
  - When EN=0: cnt=0 and pwm_out=POL.
  - Shadow period and duty (P, D) are loaded from PERIOD and DUTY on an EN 0->1 transition and at each counter wrap, so mid-period writes take effect at the next period start.
  - When EN=1 and P>0: cnt increments every cycle and wraps P-1 -> 0. pwm_out = (cnt < D) XOR POL, registered, with 1 cycle of latency from cnt.
  - P=0: cnt is held at 0 and pwm_out=POL.
  - D=0: output is always inactive.
  - D>=P: output is always active.
  - Clearing EN takes effect on the next edge.
- Reset asserted mid-transaction aborts it immediately. No response is issued, and all state returns to reset values.

Test Plan:
- Reset, then write 0x0000FFFF to PERIOD with WSTRB=4'hF -> BVALID with BRESP=00. A subsequent read of 0x4 returns 0x0000FFFF. RDATA must stay stable while RREADY is held low for 5 cycles.
- Present W 3 cycles before AW, writing 0xABCD0005 to DUTY -> WREADY drops after the W handshake and BVALID rises 1 cycle after the AW handshake. A read of 0x8 returns 0x00000005 (C_PWM_WIDTH=16).
- WSTRB=4'b0010 write of 0x12345678 to PERIOD, which holds 0x000000FF -> reads back 0x000056FF.
- PERIOD=10, DUTY=3, CTRL=1 -> pwm_out is high for 3 cycles and low for 7, repeating. Setting CTRL=3 inverts the output.
- DUTY changed from 3 to 8 mid-period -> the current period keeps 3 and the next period shows 8. DUTY=12 with PERIOD=10 gives a constant high; PERIOD=0 gives a constant POL level.
- Assert ARESETN=0 while BVALID is pending and the counter is at 5 -> BVALID, counter, pwm_out and all registers read 0 after release.
